// File: rtl/decoder_scan_ctrl.sv
// Scan controller that sequences the select/enable inputs of a downstream 3-to-8 enabled decoder.
// Optional break-before-make blank cycle between channels is enabled by defining SCAN_BLANK_EN.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               enab,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif

  state_t             r_state, w_state_next;
  logic [2:0]         r_sel, w_sel_next;
  logic [DWELL_W-1:0] r_cnt, w_cnt_next;
  logic [DWELL_W-1:0] r_dwell, w_dwell_next;
  logic [7:0]         r_mask, w_mask_next;
  logic               r_mode, w_mode_next;
  logic               r_done, w_done_next;
  logic               r_wrap, w_wrap_next;
`ifdef SCAN_BLANK_EN
  logic               r_wrap_pend, w_wrap_pend_next;
`endif

  logic [7:0] w_above;

  // Index of the lowest set bit; the caller guarantees v is non-zero.
  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign w_above = r_mask & (8'hFE << r_sel);

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_cnt_next   = r_cnt;
    w_dwell_next = r_dwell;
    w_mask_next  = r_mask;
    w_mode_next  = r_mode;
    w_done_next  = 1'b0;
    w_wrap_next  = 1'b0;
`ifdef SCAN_BLANK_EN
    w_wrap_pend_next = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          if (mask != 8'h00) begin
            w_mask_next  = mask;
            w_dwell_next = dwell;
            w_mode_next  = mode;
            w_sel_next   = lowest(mask);
            w_cnt_next   = dwell;
            w_state_next = SCAN;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          w_state_next = IDLE;
          w_sel_next   = 3'd0;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
        end else if (w_above != 8'h00) begin
          w_sel_next = lowest(w_above);
          w_cnt_next = r_dwell;
`ifdef SCAN_BLANK_EN
          w_state_next = BLANK;
`endif
        end else if (!r_mode) begin
          w_state_next = IDLE;
          w_sel_next   = 3'd0;
          w_done_next  = 1'b1;
        end else begin
          w_sel_next = lowest(r_mask);
          w_cnt_next = r_dwell;
`ifdef SCAN_BLANK_EN
          // wrap is reported on the first enabled cycle, after the blank
          w_state_next     = BLANK;
          w_wrap_pend_next = 1'b1;
`else
          w_wrap_next = 1'b1;
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        if (stop) begin
          w_state_next = IDLE;
          w_sel_next   = 3'd0;
        end else begin
          w_state_next = SCAN;
          w_wrap_next  = r_wrap_pend;
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
        w_sel_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
      r_cnt   <= '0;
      r_dwell <= '0;
      r_mask  <= 8'h00;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
`ifdef SCAN_BLANK_EN
      r_wrap_pend <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_cnt   <= w_cnt_next;
      r_dwell <= w_dwell_next;
      r_mask  <= w_mask_next;
      r_mode  <= w_mode_next;
      r_done  <= w_done_next;
      r_wrap  <= w_wrap_next;
`ifdef SCAN_BLANK_EN
      r_wrap_pend <= w_wrap_pend_next;
`endif
    end
  end

  // Outputs decode registered state only, so nothing from the inputs reaches them combinationally.
  assign sel  = r_sel;
  assign enab = (r_state == SCAN);
  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl: directed scenarios plus randomized scans
// compared cycle by cycle against a list-based reference model.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [7:0] dwell = 8'h00;
  logic [2:0] sel;
  logic       enab, busy, done, wrap;

  int n_cmp = 0;
  int n_fail = 0;

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .mask(mask), .dwell(dwell), .sel(sel), .enab(enab), .busy(busy),
    .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Reference model: the scan is a list of enabled channel numbers walked in order,
  // each shown for dwell+1 cycles counted upward.
  int  m_chans[$];
  int  m_idx = 0;
  int  m_held = 0;
  int  m_dwell = 0;
  bit  m_mode = 0;
  bit  m_busy = 0;
  bit  m_blank = 0;
  bit  m_wrap_pend = 0;
  int  exp_sel = 0;
  bit  exp_done = 0;
  bit  exp_wrap = 0;

  task automatic model_step();
    exp_done = 0;
    exp_wrap = 0;
    if (rst) begin
      m_busy = 0; m_blank = 0; m_wrap_pend = 0; exp_sel = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        if (mask != 0) begin
          m_chans.delete();
          for (int c = 0; c < 8; c++) if (mask[c]) m_chans.push_back(c);
          m_dwell = int'(dwell); m_mode = mode; m_idx = 0; m_held = 1;
          m_busy = 1; m_blank = 0; exp_sel = m_chans[0];
        end else begin
          exp_done = 1;
        end
      end
    end else if (stop) begin
      m_busy = 0; m_blank = 0; exp_sel = 0;
    end else if (m_blank) begin
      m_blank = 0; m_held = 1; exp_wrap = m_wrap_pend; m_wrap_pend = 0;
    end else if (m_held < m_dwell + 1) begin
      m_held++;
    end else if (m_idx + 1 < m_chans.size()) begin
      m_idx++; exp_sel = m_chans[m_idx]; m_held = 1;
`ifdef SCAN_BLANK_EN
      m_blank = 1;
`endif
    end else if (!m_mode) begin
      m_busy = 0; exp_sel = 0; exp_done = 1;
    end else begin
      m_idx = 0; exp_sel = m_chans[0]; m_held = 1;
`ifdef SCAN_BLANK_EN
      m_blank = 1; m_wrap_pend = 1;
`else
      exp_wrap = 1;
`endif
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs checked 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("sel",  {5'd0, sel},  8'(exp_sel));
    check("enab", {7'd0, enab}, {7'd0, (m_busy && !m_blank)});
    check("busy", {7'd0, busy}, {7'd0, m_busy});
    check("done", {7'd0, done}, {7'd0, exp_done});
    check("wrap", {7'd0, wrap}, {7'd0, exp_wrap});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    // reset then idle
    rst = 1; run(2); rst = 0; run(10);

    // single pass, mask 0000_0101, dwell 1
    mask = 8'h05; dwell = 8'd1; mode = 0; start = 1; cycle(); start = 0; run(8);

    // continuous wrap over channels 0 and 7, dwell 0
    mask = 8'h81; dwell = 8'd0; mode = 1; start = 1; cycle(); start = 0; run(10);
    stop = 1; cycle(); stop = 0; run(2);

    // abort and ignored restart
    mask = 8'hFF; dwell = 8'd3; mode = 1; start = 1; cycle(); start = 0;
    run(4); start = 1; cycle(); start = 0; run(3); stop = 1; cycle(); stop = 0; run(3);

    // empty mask gives a lone done; start with stop does nothing
    mask = 8'h00; start = 1; cycle(); start = 0; run(2);
    mask = 8'h3C; start = 1; stop = 1; cycle(); start = 0; stop = 0; run(3);

    // latched mask survives input changes; reset mid-channel
    mask = 8'h2A; dwell = 8'd2; mode = 0; start = 1; cycle(); start = 0;
    mask = 8'h01; dwell = 8'd0; mode = 1; run(5);
    rst = 1; cycle(); rst = 0; run(3);

    // single-bit continuous scan and maximum dwell
    mask = 8'h10; dwell = 8'd1; mode = 1; start = 1; cycle(); start = 0; run(9);
    stop = 1; cycle(); stop = 0;
    mask = 8'h40; dwell = 8'hFF; mode = 0; start = 1; cycle(); start = 0; run(260);

    // randomized scans with disturbance on the inputs while busy
    for (int s = 0; s < 25; s++) begin
      mask  = 8'($urandom);
      if (s % 5 == 0) mask = 8'(1 << $urandom_range(0, 7));
      dwell = 8'($urandom_range(0, 3));
      mode  = 1'($urandom % 2);
      start = 1; cycle(); start = 0;
      for (int k = 0; k < 40; k++) begin
        mask  = 8'($urandom);
        dwell = 8'($urandom_range(0, 3));
        mode  = 1'($urandom % 2);
        start = ($urandom % 8 == 0);
        stop  = ($urandom % 30 == 0);
        cycle();
      end
      start = 0; stop = 1; cycle(); stop = 0; cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequential scan controller that drives the select/enable inputs of the 3-to-8 enabled decoder directly upstream of it. On a start request it steps through a latched 8-bit channel mask and presents each enabled channel's index with enable asserted for a programmable dwell time. It runs either single-pass or continuous and reports pass completion. Typical uses are multiplexed LED digit scan, keypad row strobing and one-hot peripheral select sequencing.

## Interface
- DWELL_W, 8, width of the dwell count; each channel is held for dwell+1 cycles.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- stop  in  1  abort scan; sampled every cycle.
- mode  in  1  0 = single pass, 1 = continuous; latched at start.
- mask  in  8  channel enable mask, bit i = channel i; latched at start.
- dwell  in  DWELL_W  channel hold count minus one; latched at start.
- sel  out  3  channel index, connects to the decoder's 3-bit input.
- enab  out  1  decoder enable.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse at the end of a single pass.
- wrap  out  1  one-cycle pulse when a continuous scan wraps to its first channel.

## Operation
- Reset (rst=1 at edge): state IDLE, sel=0, enab=0, busy=0, done=0, wrap=0, latched mask/dwell/mode=0, counter=0.
- States:
  - IDLE
  - SCAN
  - BLANK (only with the configuration macro compiled in)
- IDLE:
  - enab=0, sel holds 0.
  - start=1 and stop=0 and mask≠0: latch mask/dwell/mode, set sel to the lowest set bit of mask, counter=dwell, go to SCAN.
  - start=1 and mask=0: stay in IDLE and pulse done for one cycle.
  - start and stop together: stop wins; stay in IDLE with no pulse.
- SCAN:
  - enab=1.
  - counter≠0: decrement.
  - counter=0: advance to the next set bit of the latched mask strictly above sel.
  - No higher set bit in single mode: go to IDLE and pulse done.
  - No higher set bit in continuous mode: reload the lowest set bit and pulse wrap in the first cycle of the wrapped channel.
  - Every advance reloads counter=dwell.
- Channel search is a priority search over the latched mask. Cleared bits are skipped with no dead cycles.
- Single-bit mask in continuous mode: sel stays constant and enab stays high. wrap pulses every dwell+1 cycles.
- stop=1 in SCAN or BLANK: go to IDLE next cycle with enab=0 and sel=0. No done or wrap pulse.
- start while busy: ignored.
- Changes to mask/dwell/mode inputs while busy have no effect until the next start.
- Counter is DWELL_W bits, unsigned. dwell=0 gives 1 cycle per channel; all-ones gives 2^DWELL_W cycles.

## Timing
- Start latency: start sampled at edge N gives sel=first channel, enab=1, busy=1 from edge N onward, i.e. visible in cycle N+1.
- Each channel holds enab=1 for exactly dwell+1 consecutive cycles.
- done is high in the first IDLE cycle after the last channel, with busy=0 and enab=0 in that same cycle.
- sel changes only on channel advance. sel and enab are registered; there are no combinational paths from inputs to outputs.
- rst mid-scan: outputs return to reset values at that edge. Reset takes priority over start and stop.

## Configuration
- SCAN_BLANK_EN defined:
  - Between two consecutive channels, including a continuous wrap, insert one BLANK cycle: enab=0, sel already showing the next channel (break-before-make).
  - No blank cycle before done.
  - A single-bit mask in continuous mode still blanks for one cycle every period.
- SCAN_BLANK_EN undefined: the BLANK state is absent and channels advance back-to-back with enab continuously high.

## Test plan
- Reset, then idle: rst=1 for 2 cycles, then start=0 -> sel=0, enab=0, busy=0, done=0 for 10 cycles.
- Single pass: mask=8'b00000101, dwell=1, mode=0, start at edge 0 -> cycles 1-2 sel=0 enab=1; cycles 3-4 sel=2 enab=1; cycle 5 enab=0 busy=0 done=1. With SCAN_BLANK_EN: cycle 3 sel=2 enab=0, cycles 4-5 sel=2 enab=1, done in cycle 6.
- Continuous wrap: mask=8'b10000001, dwell=0, mode=1 -> sel sequence 0,7,0,7…; wrap=1 in each cycle that sel returns to 0 after 7; done never asserts.
- Abort and ignore: start with mask=8'hFF, dwell=3, mode=1; start pulsed again at cycle 5, stop at cycle 9 -> the second start has no effect; cycle 10 enab=0 busy=0 sel=0 done=0.
- Empty mask and priority: start with mask=0 -> single done pulse with busy staying 0. start=stop=1 in IDLE -> no state change and no pulse.
- Mid-scan latch and reset: mask input changed during a scan is ignored (sequence follows the latched mask); rst at a mid-channel cycle -> all outputs at reset values in the next cycle.
